// File: rtl/mips_io_soc.sv
// mips_io_soc: key-press counter shown on LEDs and multiplexed tubes, low byte echoed over UART.
module mips_io_soc #(
   parameter int BAUD_DIV = 217,
   parameter int SCAN_DIV = 1024
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic        uart_rxd,
   output logic        uart_txd,
   input  logic        uart_rxd2,
   output logic        uart_txd2,
   input  logic [7:0]  dip_switch0,
   input  logic [7:0]  dip_switch1,
   input  logic [7:0]  dip_switch2,
   input  logic [7:0]  dip_switch3,
   input  logic [7:0]  dip_switch4,
   input  logic [7:0]  dip_switch5,
   input  logic [7:0]  dip_switch6,
   input  logic [7:0]  dip_switch7,
   input  logic [7:0]  user_key,
   output logic [31:0] led_light,
   output logic [7:0]  digital_tube0,
   output logic [3:0]  digital_tube_sel0,
   output logic [7:0]  digital_tube1,
   output logic [3:0]  digital_tube_sel1,
   output logic [7:0]  digital_tube2,
   output logic        digital_tube_sel2
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   logic [7:0]    k1_q, k2_q, k3_q, ev;
   logic [31:0]   count_q, count_d, led_q, dip;
   logic [2:0]    lk_q, lk_d;
   logic [1:0]    idx_q;
   logic [SW-1:0] scan_q;
   logic          scan_last;
   tx_state_t     st_q, st_d;
   logic [BW-1:0] baud_q, baud_d;
   logic          baud_last;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    sh_q, sh_d;
   logic          pend_q, pend_d;
   logic [7:0]    byte_q, byte_d;
   logic          txd2_q;
   logic [3:0]    nib0, nib1;
   logic          unused;
   assign unused = ^{uart_rxd, dip_switch4, dip_switch5, dip_switch6, dip_switch7};
   // keys idle high; a press is a synchronized high-to-low transition
   assign ev = k3_q & ~k2_q;
   assign dip = {~dip_switch3, ~dip_switch2, ~dip_switch1, ~dip_switch0};
   assign count_d = ev[2] ? 32'd0 : ev[1] ? dip : ev[0] ? count_q + 32'd1 : count_q;
   assign scan_last = scan_q == SW'(SCAN_DIV - 1);
   assign baud_last = baud_q == BW'(BAUD_DIV - 1);
   always_comb begin
      lk_d = lk_q;
      for (int i = 7; i >= 0; i--) if (ev[i]) lk_d = 3'(i);
   end
   always_comb begin
      st_d = st_q;
      baud_d = baud_q;
      bit_d = bit_q;
      sh_d = sh_q;
      pend_d = pend_q;
      byte_d = byte_q;
      if (st_q == TX_IDLE && pend_q) begin
         st_d = TX_SEND;
         baud_d = '0;
         bit_d = '0;
         sh_d = {1'b1, byte_q, 1'b0};
         pend_d = 1'b0;
      end else if (st_q == TX_SEND) begin
         baud_d = baud_last ? '0 : baud_q + 1'b1;
         if (baud_last) begin
            sh_d = {1'b1, sh_q[9:1]};
            bit_d = bit_q + 1'b1;
            st_d = (bit_q == 4'd9) ? TX_IDLE : TX_SEND;
         end
      end
      // single pending slot: the newest changed value wins
      if (count_d != count_q) begin
         pend_d = 1'b1;
         byte_d = count_d[7:0];
      end
   end
   always_ff @(posedge clk_in) begin
      if (sys_rstn) begin
         k1_q <= '1;
         k2_q <= '1;
         k3_q <= '1;
         count_q <= '0;
         lk_q <= '0;
         led_q <= '1;
         idx_q <= '0;
         scan_q <= '0;
         st_q <= TX_IDLE;
         baud_q <= '0;
         bit_q <= '0;
         sh_q <= '1;
         pend_q <= 1'b0;
         byte_q <= '0;
         txd2_q <= 1'b1;
      end else begin
         k1_q <= user_key;
         k2_q <= k1_q;
         k3_q <= k2_q;
         count_q <= count_d;
         lk_q <= lk_d;
         led_q <= ~count_q;
         scan_q <= scan_last ? '0 : scan_q + 1'b1;
         idx_q <= idx_q + {1'b0, scan_last};
         st_q <= st_d;
         baud_q <= baud_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         pend_q <= pend_d;
         byte_q <= byte_d;
         txd2_q <= uart_rxd2;
      end
   end
   assign nib0 = idx_q == 2'd0 ? count_q[3:0] : idx_q == 2'd1 ? count_q[7:4] :
                 idx_q == 2'd2 ? count_q[11:8] : count_q[15:12];
   assign nib1 = idx_q == 2'd0 ? count_q[19:16] : idx_q == 2'd1 ? count_q[23:20] :
                 idx_q == 2'd2 ? count_q[27:24] : count_q[31:28];
   assign uart_txd = (st_q == TX_IDLE) | sh_q[0];
   assign uart_txd2 = txd2_q;
   assign led_light = led_q;
   assign digital_tube0 = GLYPH[nib0];
   assign digital_tube1 = GLYPH[nib1];
   assign digital_tube2 = GLYPH[{1'b0, lk_q}];
   assign digital_tube_sel0 = 4'b0001 << idx_q;
   assign digital_tube_sel1 = 4'b0001 << idx_q;
   assign digital_tube_sel2 = 1'b1;
endmodule

// File: tb/tb_mips_io_soc.sv
// tb_mips_io_soc: vector table, randomized presses against a count model, UART frame and loopback sequences.
module tb_mips_io_soc;
   localparam int BAUD = 217;
   localparam logic [7:0] GL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   typedef struct packed {
      logic [7:0]  keys;
      logic [31:0] dip;
      logic [31:0] led;
      logic [2:0]  lk;
   } vec_t;
   logic clk_in = 1'b0;
   logic sys_rstn = 1'b1;
   logic uart_rxd = 1'b1, uart_rxd2 = 1'b1;
   logic uart_txd, uart_txd2;
   logic [7:0] dip_switch0 = '1, dip_switch1 = '1, dip_switch2 = '1, dip_switch3 = '1;
   logic [7:0] dip_switch4 = '1, dip_switch5 = '1, dip_switch6 = '1, dip_switch7 = '1;
   logic [7:0] user_key = '1;
   logic [31:0] led_light;
   logic [7:0] digital_tube0, digital_tube1, digital_tube2;
   logic [3:0] digital_tube_sel0, digital_tube_sel1;
   logic digital_tube_sel2;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] m_count = 0;
   logic [2:0] m_lk = 0;
   vec_t tbl [11];

   mips_io_soc dut (
      .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .uart_rxd2(uart_rxd2), .uart_txd2(uart_txd2),
      .dip_switch0(dip_switch0), .dip_switch1(dip_switch1), .dip_switch2(dip_switch2),
      .dip_switch3(dip_switch3), .dip_switch4(dip_switch4), .dip_switch5(dip_switch5),
      .dip_switch6(dip_switch6), .dip_switch7(dip_switch7), .user_key(user_key),
      .led_light(led_light), .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
      .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
      .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
   );

   always #20 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_dip(input logic [31:0] v);
      dip_switch0 = ~v[7:0];
      dip_switch1 = ~v[15:8];
      dip_switch2 = ~v[23:16];
      dip_switch3 = ~v[31:24];
   endtask

   // count rules: clear beats load beats increment; last key is the lowest index pressed
   task automatic model_press(input logic [7:0] m, input logic [31:0] d);
      if (m[2]) m_count = 0;
      else if (m[1]) m_count = d;
      else if (m[0]) m_count = m_count + 1;
      for (int i = 0; i < 8; i++) if (m[i]) begin
         m_lk = 3'(i);
         break;
      end
   endtask

   task automatic press(input logic [7:0] m, input logic [31:0] d);
      set_dip(d);
      @(negedge clk_in) user_key = ~m;
      repeat (3) @(negedge clk_in);
      user_key = '1;
      repeat (4) @(negedge clk_in);
      model_press(m, d);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk_in) sys_rstn = 1'b1;
      repeat (n) @(negedge clk_in);
      sys_rstn = 1'b0;
      m_count = 0;
      m_lk = 0;
   endtask

   task automatic check_tubes(input string tag);
      int i0, i1;
      i0 = -1;
      i1 = -1;
      for (int k = 0; k < 4; k++) begin
         if (digital_tube_sel0 === 4'(1 << k)) i0 = k;
         if (digital_tube_sel1 === 4'(1 << k)) i1 = k;
      end
      check({tag, " sel0 onehot"}, 32'(i0 >= 0), 32'd1);
      check({tag, " sel1 onehot"}, 32'(i1 >= 0), 32'd1);
      if (i0 >= 0) check({tag, " tube0"}, 32'(digital_tube0), 32'(GL[4'(m_count >> (4 * i0))]));
      if (i1 >= 0) check({tag, " tube1"}, 32'(digital_tube1), 32'(GL[4'(m_count >> (16 + 4 * i1))]));
      check({tag, " tube2"}, 32'(digital_tube2), 32'(GL[{1'b0, m_lk}]));
   endtask

   task automatic wait_sel(input logic [3:0] s, input bit which, input string name);
      int t = 0;
      while (((which ? digital_tube_sel1 : digital_tube_sel0) !== s) && t < 5000) begin
         @(negedge clk_in);
         t++;
      end
      check(name, 32'(t < 5000), 32'd1);
   endtask

   task automatic uart_frame(input logic [7:0] b, input string name);
      logic [9:0] fr;
      logic [7:0] got;
      int t, errs;
      fr = {1'b1, b, 1'b0};
      got = '0;
      t = 0;
      errs = 0;
      while (uart_txd !== 1'b0 && t < 5000) begin
         @(negedge clk_in);
         t++;
      end
      check({name, " start"}, 32'(t < 5000), 32'd1);
      for (int i = 0; i < 10 * BAUD; i++) begin
         if (uart_txd !== fr[i / BAUD]) errs++;
         if (i % BAUD == BAUD / 2 && i / BAUD >= 1 && i / BAUD <= 8) got[i / BAUD - 1] = uart_txd;
         @(negedge clk_in);
      end
      check({name, " waveform errors"}, 32'(errs), 32'd0);
      check({name, " byte"}, 32'(got), 32'(b));
   endtask

   task automatic watch_idle(input int n, input string name);
      int lows = 0;
      repeat (n) begin
         @(negedge clk_in);
         if (uart_txd !== 1'b1) lows++;
      end
      check(name, 32'(lows), 32'd0);
   endtask

   initial begin
      #8000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic prev, v;
      logic [7:0] m;
      logic [31:0] d;
      tbl[0]  = '{keys: 8'h01, dip: 32'h0000_0000, led: 32'hFFFF_FFFE, lk: 3'd0};
      tbl[1]  = '{keys: 8'h02, dip: 32'h1234_5678, led: 32'hEDCB_A987, lk: 3'd1};
      tbl[2]  = '{keys: 8'h01, dip: 32'h1234_5678, led: 32'hEDCB_A986, lk: 3'd0};
      tbl[3]  = '{keys: 8'h08, dip: 32'h0000_0000, led: 32'hEDCB_A986, lk: 3'd3};
      tbl[4]  = '{keys: 8'h80, dip: 32'h0000_0000, led: 32'hEDCB_A986, lk: 3'd7};
      tbl[5]  = '{keys: 8'h06, dip: 32'h1234_5678, led: 32'hFFFF_FFFF, lk: 3'd1};
      tbl[6]  = '{keys: 8'h03, dip: 32'hFFFF_FFFE, led: 32'h0000_0001, lk: 3'd0};
      tbl[7]  = '{keys: 8'h01, dip: 32'h0000_0000, led: 32'h0000_0000, lk: 3'd0};
      tbl[8]  = '{keys: 8'h01, dip: 32'h0000_0000, led: 32'hFFFF_FFFF, lk: 3'd0};
      tbl[9]  = '{keys: 8'h30, dip: 32'h0000_0000, led: 32'hFFFF_FFFF, lk: 3'd4};
      tbl[10] = '{keys: 8'h04, dip: 32'h0000_0000, led: 32'hFFFF_FFFF, lk: 3'd2};

      repeat (10) @(negedge clk_in);
      check("reset led", led_light, 32'hFFFF_FFFF);
      check("reset txd", 32'(uart_txd), 32'd1);
      check("reset txd2", 32'(uart_txd2), 32'd1);
      check("reset tube0", 32'(digital_tube0), 32'hC0);
      check("reset tube1", 32'(digital_tube1), 32'hC0);
      check("reset tube2", 32'(digital_tube2), 32'hC0);
      check("reset sel0", 32'(digital_tube_sel0), 32'h1);
      check("reset sel1", 32'(digital_tube_sel1), 32'h1);
      check("reset sel2", 32'(digital_tube_sel2), 32'd1);
      sys_rstn = 1'b0;

      repeat (9) press(8'h01, 32'h0);
      check("nine presses led", led_light, 32'hFFFF_FFF6);
      wait_sel(4'b0001, 1'b0, "find sel0 digit0");
      check("count 9 tube0 digit0", 32'(digital_tube0), 32'h90);
      check("count 9 tube2", 32'(digital_tube2), 32'hC0);

      press(8'h02, 32'hFFFF_FFFF);
      check("load all-ones led", led_light, 32'h0);
      check("load tube2", 32'(digital_tube2), 32'hF9);
      wait_sel(4'b1000, 1'b1, "find sel1 digit3");
      check("all-ones tube1 digit3", 32'(digital_tube1), 32'h8E);
      press(8'h01, 32'h0);
      check("wrap led", led_light, 32'hFFFF_FFFF);

      press(8'h01, 32'h0);
      press(8'h07, 32'h5555_AAAA);
      check("keys 0,1,2 together led", led_light, 32'hFFFF_FFFF);
      check("keys 0,1,2 together tube2", 32'(digital_tube2), 32'hC0);

      do_reset(2);
      foreach (tbl[i]) begin
         press(tbl[i].keys, tbl[i].dip);
         check($sformatf("vec%0d led", i), led_light, tbl[i].led);
         check($sformatf("vec%0d tube2", i), 32'(digital_tube2), 32'(GL[{1'b0, tbl[i].lk}]));
         check_tubes($sformatf("vec%0d", i));
      end

      for (int n = 0; n < 60; n++) begin
         m = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'($urandom_range(1, 255));
         d = $urandom;
         press(m, d);
         check($sformatf("rand%0d led", n), led_light, ~m_count);
         check_tubes($sformatf("rand%0d", n));
      end

      @(posedge clk_in);
      #5 user_key[0] = 1'b0;
      #10 user_key[0] = 1'b1;
      repeat (6) @(negedge clk_in);
      check("short pulse ignored", led_light, ~m_count);

      prev = uart_rxd2;
      for (int n = 0; n < 8; n++) begin
         v = ~prev;
         @(negedge clk_in) uart_rxd2 = v;
         #1 check($sformatf("loopback%0d hold", n), 32'(uart_txd2), 32'(prev));
         @(negedge clk_in);
         check($sformatf("loopback%0d follow", n), 32'(uart_txd2), 32'(v));
         prev = v;
      end

      do_reset(2);
      press(8'h04, 32'h0);
      watch_idle(300, "clear to same value sends nothing");
      fork
         begin
            uart_frame(8'h01, "frame1");
            uart_frame(8'h02, "frame2");
         end
         begin
            @(negedge clk_in) user_key = 8'hFE;
            repeat (1000) @(negedge clk_in);
            user_key = '1;
            repeat (3) @(negedge clk_in);
            user_key = 8'hFE;
            repeat (4) @(negedge clk_in);
            user_key = '1;
         end
      join
      m_count = 2;
      check("after frames led", led_light, 32'hFFFF_FFFD);

      @(negedge clk_in) user_key = 8'hFE;
      repeat (600) @(negedge clk_in);
      sys_rstn = 1'b1;
      @(negedge clk_in);
      check("mid-frame reset txd", 32'(uart_txd), 32'd1);
      user_key = '1;
      @(negedge clk_in) sys_rstn = 1'b0;
      m_count = 0;
      m_lk = 0;
      watch_idle(500, "aborted frame stays idle");
      check("after abort led", led_light, 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
